// File: rtl/ld_st_pkg.sv
// ---------------------------------------------------------------------------
// ld_st_pkg
// Shared definitions for the LD_ST register sequencer:
//   - op_t        : word command encodings (NOP / LOAD / CLEAR / SET)
//   - state_t     : sequencer FSM states (INIT / IDLE / DRIVE / CHECK / RESP)
//   - slice_ctrl_t: one slice's control bundle {LD_ST, set_n, clr_n, slIn}
//   - SLICE_HOLD  : control bundle that leaves a slice unchanged
// ---------------------------------------------------------------------------
package ld_st_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_SET   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_CHECK = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    typedef struct packed {
        logic ld_st;
        logic set_n;
        logic clr_n;
        logic sl_in;
    } slice_ctrl_t;

    localparam slice_ctrl_t SLICE_HOLD = '{ld_st: 1'b0, set_n: 1'b1, clr_n: 1'b1, sl_in: 1'b0};

endpackage

// File: rtl/ld_st_slice_drv.sv
// ---------------------------------------------------------------------------
// ld_st_slice_drv
// Combinational per-bit control encoder. Maps the word command onto one
// slice's control bundle; the top registers the result.
// Ports:
//   op   in  2   command op (op_t encoding)
//   mask in  1   1 = this bit is affected, 0 = hold
//   data in  1   load data for this bit (LOAD only)
//   ctrl out 4   {ld_st, set_n, clr_n, sl_in} for this slice
// ---------------------------------------------------------------------------
module ld_st_slice_drv
    import ld_st_pkg::*;
(
    input  logic [1:0]  op,
    input  logic        mask,
    input  logic        data,
    output slice_ctrl_t ctrl
);

    always_comb begin
        ctrl = SLICE_HOLD;
        if (mask) begin
            case (op_t'(op))
                OP_LOAD:  ctrl = '{ld_st: 1'b1, set_n: 1'b1, clr_n: 1'b1, sl_in: data};
                OP_CLEAR: ctrl.clr_n = 1'b0;
                OP_SET:   ctrl.set_n = 1'b0;
                default:  ctrl = SLICE_HOLD;
            endcase
        end
    end

endmodule

// File: rtl/ld_st_reg_ctrl.sv
// ---------------------------------------------------------------------------
// ld_st_reg_ctrl
// Sequencer for a WIDTH-bit word of LD_ST register slices. Accepts one word
// command at a time, drives the slice controls for exactly one capture edge,
// reads the word back and reports the per-bit difference to a shadow copy of
// the commanded value.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. cmd_ready is 1 only in IDLE; rsp_valid is 1 only in RESP and
// stays up (with rsp_* stable) until rsp_ready is seen.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/ready/op/mask/data   command port
//   LD_ST, set_n, clr_n, slIn  registered per-slice controls
//   slOut                      slice array readback
//   rsp_valid/ready/err/mismatch   response port
//   err_count                  saturating count of failed checks
//   fsm_state                  current FSM state (debug)
// ---------------------------------------------------------------------------
module ld_st_reg_ctrl
    import ld_st_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ERR_CW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_mask,
    input  logic [WIDTH-1:0]  cmd_data,
    output logic [WIDTH-1:0]  LD_ST,
    output logic [WIDTH-1:0]  set_n,
    output logic [WIDTH-1:0]  clr_n,
    output logic [WIDTH-1:0]  slIn,
    input  logic [WIDTH-1:0]  slOut,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_err,
    output logic [WIDTH-1:0]  rsp_mismatch,
    output logic [ERR_CW-1:0] err_count,
    output state_t            fsm_state
);

    localparam logic [ERR_CW-1:0] ERR_ONE = {{(ERR_CW-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] opval;
    logic [WIDTH-1:0] mismatch_nxt;
    logic             err_nxt;
    logic [WIDTH-1:0] drv_ld_st;
    logic [WIDTH-1:0] drv_set_n;
    logic [WIDTH-1:0] drv_clr_n;
    logic [WIDTH-1:0] drv_sl_in;

    assign accept = cmd_valid & cmd_ready;

    // Per-slice encoders
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        slice_ctrl_t c;
        ld_st_slice_drv u_drv (
            .op   (cmd_op),
            .mask (cmd_mask[i]),
            .data (cmd_data[i]),
            .ctrl (c)
        );
        assign drv_ld_st[i] = c.ld_st;
        assign drv_set_n[i] = c.set_n;
        assign drv_clr_n[i] = c.clr_n;
        assign drv_sl_in[i] = c.sl_in;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ST_IDLE;
            ST_IDLE:  if (accept) state_nxt = ST_DRIVE;
            ST_DRIVE: state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        fsm_state = state;
    end

    // Slice controls. Reset holds clr_n low to clear the (unreset) slice
    // array; every edge other than an accept returns all slices to hold,
    // so commanded controls are present for exactly one capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            LD_ST <= '0;
            set_n <= '1;
            clr_n <= '0;
            slIn  <= '0;
        end else if (accept) begin
            LD_ST <= drv_ld_st;
            set_n <= drv_set_n;
            clr_n <= drv_clr_n;
            slIn  <= drv_sl_in;
        end else begin
            LD_ST <= {WIDTH{SLICE_HOLD.ld_st}};
            set_n <= {WIDTH{SLICE_HOLD.set_n}};
            clr_n <= {WIDTH{SLICE_HOLD.clr_n}};
            slIn  <= {WIDTH{SLICE_HOLD.sl_in}};
        end
    end

    // Value the masked bits take after the command; NOP keeps the shadow.
    always_comb begin
        opval = shadow;
        case (op_t'(cmd_op))
            OP_LOAD:  opval = cmd_data;
            OP_CLEAR: opval = '0;
            OP_SET:   opval = '1;
            default:  opval = shadow;
        endcase
    end

    // Shadow tracks the commanded word only; readback never corrects it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      shadow <= '0;
        else if (accept) shadow <= (shadow & ~cmd_mask) | (cmd_mask & opval);
    end

    assign mismatch_nxt = slOut ^ shadow;
    assign err_nxt      = |mismatch_nxt;

    // Checker: response fields only change in CHECK, so they stay stable
    // through RESP regardless of rsp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_mismatch <= '0;
            rsp_err      <= 1'b0;
            err_count    <= '0;
        end else if (state == ST_CHECK) begin
            rsp_mismatch <= mismatch_nxt;
            rsp_err      <= err_nxt;
            if (err_nxt && (err_count != '1)) err_count <= err_count + ERR_ONE;
        end
    end

endmodule

// File: tb/tb_ld_st_reg_ctrl.sv
module tb_ld_st_reg_ctrl;
    import ld_st_pkg::*;

    localparam int W     = 8;
    localparam int BOUND = 50;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op    = 2'b00;
    logic [W-1:0] cmd_mask  = '0;
    logic [W-1:0] cmd_data  = '0;
    logic [W-1:0] ld_st, set_n, clr_n, sl_in, sl_out;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_err;
    logic [W-1:0] rsp_mismatch;
    logic [7:0]   err_count;
    state_t       fsm_state;

    ld_st_reg_ctrl #(.WIDTH(W), .ERR_CW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_mask     (cmd_mask),
        .cmd_data     (cmd_data),
        .LD_ST        (ld_st),
        .set_n        (set_n),
        .clr_n        (clr_n),
        .slIn         (sl_in),
        .slOut        (sl_out),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_err      (rsp_err),
        .rsp_mismatch (rsp_mismatch),
        .err_count    (err_count),
        .fsm_state    (fsm_state)
    );

    // Slice array: unreset flops, clr dominates set dominates load.
    // stuck0 forces readback bits to 0 to emulate a broken slice.
    logic [W-1:0] slice_q;
    logic [W-1:0] stuck0 = '0;
    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (!clr_n[i])      slice_q[i] <= 1'b0;
            else if (!set_n[i]) slice_q[i] <= 1'b1;
            else if (ld_st[i])  slice_q[i] <= sl_in[i];
        end
    end
    assign sl_out = slice_q & ~stuck0;

    // reference model + scoreboard
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [W-1:0] model_word = '0;
    logic [7:0]   model_cnt  = '0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] apply_op(input logic [W-1:0] w, input logic [1:0] op,
                                              input logic [W-1:0] mask, input logic [W-1:0] data);
        logic [W-1:0] r;
        r = w;
        for (int i = 0; i < W; i++) begin
            if (mask[i]) begin
                if (op == 2'b01)      r[i] = data[i];
                else if (op == 2'b10) r[i] = 1'b0;
                else if (op == 2'b11) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // One full command/response with rsp_ready high, checked against the model.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] mask, input logic [W-1:0] data);
        logic [W-1:0] exp_mis;
        logic [W-1:0] exp_sl;
        int n;
        @(negedge clk);
        cmd_op = op; cmd_mask = mask; cmd_data = data; cmd_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        model_word = apply_op(model_word, op, mask, data);
        exp_sl  = model_word & ~stuck0;
        exp_mis = exp_sl ^ model_word;
        if (exp_mis != '0 && model_cnt != 8'hFF) model_cnt = model_cnt + 8'd1;
        exp_q.push_back(exp_mis);
        @(negedge clk);
        n = 0;
        while (rsp_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        exp_mis = exp_q.pop_front();
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
            return;
        end
        tests_run++;
        if (rsp_mismatch !== exp_mis) begin
            tests_failed++;
            $display("FAIL rsp_mismatch op=%0d mask=%h data=%h: got %h exp %h", op, mask, data, rsp_mismatch, exp_mis);
        end
        tests_run++;
        if (rsp_err !== (|exp_mis)) begin
            tests_failed++;
            $display("FAIL rsp_err: got %b exp %b", rsp_err, |exp_mis);
        end
        tests_run++;
        if (err_count !== model_cnt) begin
            tests_failed++;
            $display("FAIL err_count: got %h exp %h", err_count, model_cnt);
        end
        tests_run++;
        if (sl_out !== exp_sl) begin
            tests_failed++;
            $display("FAIL slout_after_cmd: got %h exp %h", sl_out, exp_sl);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (clr_n !== 8'h00 || set_n !== 8'hFF || ld_st !== 8'h00 || sl_in !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_ctrl: clr_n=%h set_n=%h ld_st=%h sl_in=%h exp 00/FF/00/00", clr_n, set_n, ld_st, sl_in);
        end
        tests_run++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_mismatch !== 8'h00 || err_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rsp: cmd_ready=%b rsp_valid=%b rsp_err=%b mis=%h cnt=%h exp all 0", cmd_ready, rsp_valid, rsp_err, rsp_mismatch, err_count);
        end
        tests_run++;
        if (sl_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_slout: got %h exp 00", sl_out);
        end
        rst_n = 1'b1;
        model_word = '0; model_cnt = '0;
        @(posedge clk); #1;
        tests_run++;
        if (clr_n !== 8'hFF || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_init: clr_n=%h cmd_ready=%b exp FF/1", clr_n, cmd_ready);
        end
    endtask

    task automatic test_load_a5();
        @(negedge clk);
        cmd_op = 2'b01; cmd_mask = 8'hFF; cmd_data = 8'hA5; cmd_valid = 1'b1; rsp_ready = 1'b1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_ready: got %b exp 1", cmd_ready);
        end
        @(posedge clk); #1;          // E0: accept
        cmd_valid = 1'b0;
        model_word = 8'hA5;
        tests_run++;
        if (ld_st !== 8'hFF || sl_in !== 8'hA5 || clr_n !== 8'hFF || set_n !== 8'hFF || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_drive: ld_st=%h sl_in=%h clr_n=%h set_n=%h rdy=%b exp FF/A5/FF/FF/0", ld_st, sl_in, clr_n, set_n, cmd_ready);
        end
        @(posedge clk); #1;          // E1: capture
        tests_run++;
        if (sl_out !== 8'hA5 || ld_st !== 8'h00 || sl_in !== 8'h00 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_capture: slout=%h ld_st=%h sl_in=%h rsp_valid=%b exp A5/00/00/0", sl_out, ld_st, sl_in, rsp_valid);
        end
        @(posedge clk); #1;          // E2: compare
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_mismatch !== 8'h00 || err_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL load_rsp: valid=%b err=%b mis=%h cnt=%h exp 1/0/00/00", rsp_valid, rsp_err, rsp_mismatch, err_count);
        end
        @(posedge clk); #1;          // E3: response consumed
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_done: rsp_valid=%b cmd_ready=%b exp 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_set_clear();
        run_cmd(2'b11, 8'h0F, 8'h00);
        tests_run++;
        if (sl_out !== 8'hAF) begin
            tests_failed++;
            $display("FAIL set_0f: got %h exp AF", sl_out);
        end
        run_cmd(2'b10, 8'h80, 8'hFF);
        tests_run++;
        if (sl_out !== 8'h2F) begin
            tests_failed++;
            $display("FAIL clear_80: got %h exp 2F", sl_out);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_op = 2'b11; cmd_mask = 8'hF0; cmd_data = 8'h00; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        model_word = apply_op(model_word, 2'b11, 8'hF0, 8'h00);
        // a different command stays offered while the response is stalled
        cmd_op = 2'b01; cmd_mask = 8'hFF; cmd_data = 8'h00;
        n = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_rsp_timeout: rsp_valid=%b exp 1", rsp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_mismatch !== 8'h00 || rsp_err !== 1'b0 ||
                err_count !== model_cnt || ld_st !== 8'h00 || set_n !== 8'hFF || clr_n !== 8'hFF || sl_out !== model_word) begin
                tests_failed++;
                $display("FAIL bp_hold c=%0d: rdy=%b vld=%b mis=%h err=%b cnt=%h ld=%h sn=%h cn=%h slout=%h exp 0/1/00/0/%h/00/FF/FF/%h",
                         c, cmd_ready, rsp_valid, rsp_mismatch, rsp_err, err_count, ld_st, set_n, clr_n, sl_out, model_cnt, model_word);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || sl_out !== model_word) begin
            tests_failed++;
            $display("FAIL bp_release: vld=%b rdy=%b slout=%h exp 0/1/%h", rsp_valid, cmd_ready, sl_out, model_word);
        end
    endtask

    task automatic test_stuck_saturate();
        stuck0 = 8'h08;
        run_cmd(2'b01, 8'hFF, 8'hFF);
        tests_run++;
        if (rsp_mismatch !== 8'h08 || rsp_err !== 1'b1 || err_count !== 8'h01) begin
            tests_failed++;
            $display("FAIL stuck_first: mis=%h err=%b cnt=%h exp 08/1/01", rsp_mismatch, rsp_err, err_count);
        end
        for (int k = 0; k < 300; k++) run_cmd(2'b01, 8'hFF, 8'hFF);
        tests_run++;
        if (err_count !== 8'hFF) begin
            tests_failed++;
            $display("FAIL err_saturate: got %h exp FF", err_count);
        end
        stuck0 = 8'h00;
    endtask

    task automatic test_reset_mid_op();
        int n;
        @(negedge clk);
        cmd_op = 2'b01; cmd_mask = 8'hFF; cmd_data = 8'h3C; cmd_valid = 1'b1; rsp_ready = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        tests_run++;
        if (fsm_state !== ST_DRIVE || ld_st !== 8'hFF) begin
            tests_failed++;
            $display("FAIL mid_in_drive: state=%0d ld_st=%h exp DRIVE/FF", fsm_state, ld_st);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || clr_n !== 8'h00 || ld_st !== 8'h00 || err_count !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_async: vld=%b rdy=%b clr_n=%h ld=%h cnt=%h exp 0/0/00/00/00", rsp_valid, cmd_ready, clr_n, ld_st, err_count);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (sl_out !== 8'h00 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_cleared: slout=%h vld=%b exp 00/0", sl_out, rsp_valid);
        end
        rst_n = 1'b1;
        model_word = '0; model_cnt = '0;
        exp_q.delete();
        // scrub readback: a stale shadow would show up as a mismatch
        run_cmd(2'b00, 8'hFF, 8'hFF);
        run_cmd(2'b01, 8'h0F, 8'h3C);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_a5();
        test_set_clear();
        test_random();
        test_backpressure();
        test_stuck_saturate();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
